// File: rtl/complex_addsub_rr_scheduler_if.sv
// Requester-side bus of the complex add/sub scheduler: per-requester request
// lanes plus the shared tagged response strobe.
interface complex_addsub_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // A request on lane i transfers in any cycle where req_valid[i] && req_ready[i];
  // while valid and not ready the requester holds req_a/req_b/req_op stable.
  // resp_valid is a single-cycle strobe with no backpressure.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_op;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [63:0]           resp_data;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/complex_addsub_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined complex adder/subtractor between
// NUM_REQ requesters; a tag pipeline returns each result with its requester ID.
module complex_addsub_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ADD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  complex_addsub_rr_scheduler_if.slave req_if,
  output logic                        add_start,
  output logic [63:0]                 add_a,
  output logic [63:0]                 add_b,
  output logic                        add_op,
  output logic                        add_ce,
  input  logic [63:0]                 add_result,
  output logic                        busy,
  output logic [ID_W-1:0]             dbg_ptr_o
);

  logic [ID_W-1:0]                   ptr_q, ptr_d;
  logic                              add_start_q;
  logic [63:0]                       add_a_q, add_b_q;
  logic                              add_op_q;
  logic [ID_W-1:0]                   issue_id_q;
  logic [ADD_LATENCY-1:0]            tag_vld_q;
  logic [ADD_LATENCY-1:0][ID_W-1:0]  tag_id_q;

  logic [NUM_REQ-1:0] vld_eff;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_id;
  logic [63:0]        sel_a, sel_b;
  logic               sel_op;

  assign vld_eff = req_if.req_valid & {NUM_REQ{~(pause | rst)}};

  // Two passes realise the rotated search: first indices at or above ptr,
  // then the wrap-around below ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && vld_eff[i] && (ID_W'(i) >= ptr_q)) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
        sel_a   = req_if.req_a[64*i +: 64];
        sel_b   = req_if.req_b[64*i +: 64];
        sel_op  = req_if.req_op[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && vld_eff[i] && (ID_W'(i) < ptr_q)) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
        sel_a   = req_if.req_a[64*i +: 64];
        sel_b   = req_if.req_b[64*i +: 64];
        sel_op  = req_if.req_op[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  assign req_if.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_op_q    <= 1'b0;
      issue_id_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_start_q <= gnt_any;
      issue_id_q  <= gnt_id;
      if (gnt_any) begin
        add_a_q  <= sel_a;
        add_b_q  <= sel_b;
        add_op_q <= sel_op;
      end
      // Tag stage k is valid exactly when the adder is k+1 cycles past its start.
      tag_vld_q[0] <= add_start_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_op    = add_op_q;
  assign add_ce    = ~rst;
  assign busy      = add_start_q | (|tag_vld_q);
  assign dbg_ptr_o = ptr_q;

  // Response fields are forced to zero outside the strobe so idle adder output never leaks.
  assign req_if.resp_valid = tag_vld_q[ADD_LATENCY-1];
  assign req_if.resp_id    = tag_vld_q[ADD_LATENCY-1] ? tag_id_q[ADD_LATENCY-1] : '0;
  assign req_if.resp_data  = tag_vld_q[ADD_LATENCY-1] ? add_result : '0;

endmodule

// File: tb/tb_complex_addsub_rr_scheduler.sv
// Directed bench for complex_addsub_rr_scheduler: per-cycle grant table plus
// hand sequences for reset, pause, single-op latency and subtract passthrough.
module tb_complex_addsub_rr_scheduler;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, pause;
  logic add_start, add_op, add_ce, busy;
  logic [63:0] add_a, add_b, add_result;
  logic [IW-1:0] dbg_ptr;
  int cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  complex_addsub_rr_scheduler_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  complex_addsub_rr_scheduler #(.NUM_REQ(N), .ID_W(IW), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .pause(pause), .req_if(bus),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_ce(add_ce), .add_result(add_result), .busy(busy), .dbg_ptr_o(dbg_ptr)
  );

  // Small-integer float model: operands stay within -8..8 so values are exact.
  function automatic logic [31:0] i2f(input int n);
    logic [31:0] m;
    int a;
    a = (n < 0) ? -n : n;
    case (a)
      0: m = 32'h00000000;
      1: m = 32'h3F800000;
      2: m = 32'h40000000;
      3: m = 32'h40400000;
      4: m = 32'h40800000;
      5: m = 32'h40A00000;
      6: m = 32'h40C00000;
      7: m = 32'h40E00000;
      8: m = 32'h41000000;
      default: m = 32'h7FC00000;
    endcase
    if (n < 0) m[31] = 1'b1;
    return m;
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int v;
    case (f[30:0])
      31'h00000000: v = 0;
      31'h3F800000: v = 1;
      31'h40000000: v = 2;
      31'h40400000: v = 3;
      31'h40800000: v = 4;
      31'h40A00000: v = 5;
      31'h40C00000: v = 6;
      31'h40E00000: v = 7;
      31'h41000000: v = 8;
      default:      v = 99;
    endcase
    return f[31] ? -v : v;
  endfunction

  function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b, input logic op);
    int re, im;
    re = op ? f2i(a[63:32]) - f2i(b[63:32]) : f2i(a[63:32]) + f2i(b[63:32]);
    im = op ? f2i(a[31:0])  - f2i(b[31:0])  : f2i(a[31:0])  + f2i(b[31:0]);
    return {i2f(re), i2f(im)};
  endfunction

  // Pipelined adder model with a two-cycle start-to-result delay.
  logic [63:0] st1, st2;
  always @(posedge clk) begin
    st1 <= cadd(add_a, add_b, add_op);
    st2 <= st1;
  end
  assign add_result = st2;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [IW+63:0] exp_q[$];
  int due_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic push_exp(input int id);
    exp_q.push_back({IW'(id), cadd(bus.req_a[64*id +: 64], bus.req_b[64*id +: 64], bus.req_op[id])});
    due_q.push_back(cyc + LAT + 1);
  endtask

  always @(negedge clk) begin
    logic [IW+63:0] e;
    int d;
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected @cyc %0d: got id %0d data %h expected no response",
                 cyc, bus.resp_id, bus.resp_data);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("resp_id", 64'(bus.resp_id), 64'(e[IW+63:64]));
        check("resp_data", bus.resp_data, e[63:0]);
        check("resp_cycle", 64'(cyc), 64'(d));
      end
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      total++;
      bad++;
      $display("FAIL resp_missing @cyc %0d: got no resp_valid expected id %0d",
               cyc, exp_q[0][IW+63:64]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b, input logic op);
    bus.req_a[64*i +: 64] = a;
    bus.req_b[64*i +: 64] = b;
    bus.req_op[i]         = op;
  endtask

  task automatic load_defaults();
    for (int i = 0; i < N; i++)
      set_ops(i, {i2f(i + 1), i2f(1)}, {i2f(1), i2f(2)}, (i % 2) == 1);
  endtask

  task automatic flush_inflight();
    while (due_q.size() > 0 && due_q[$] > cyc) begin
      void'(due_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    pause = 1'b0;
    bus.req_valid = '1;
    #1;
    check("ready_in_rst", 64'(bus.req_ready), 64'h0);
    check("add_ce_in_rst", 64'(add_ce), 64'h0);
    flush_inflight();
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_add_start", 64'(add_start), 64'h0);
    check("rst_add_a", add_a, 64'h0);
    check("rst_add_b", add_b, 64'h0);
    check("rst_add_op", 64'(add_op), 64'h0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    check("rst_resp_id", 64'(bus.resp_id), 64'h0);
    check("rst_resp_data", bus.resp_data, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ptr", 64'(dbg_ptr), 64'h0);
    check("add_ce_run", 64'(add_ce), 64'h1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      bus.req_valid = '0;
      pause = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] valid;
    logic         pause;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    bus.req_valid = '0;
    load_defaults();

    // all four requesting from ptr=0
    tbl.push_back('{4'b1111, 1'b0, 4'b0001});
    tbl.push_back('{4'b1111, 1'b0, 4'b0010});
    tbl.push_back('{4'b1111, 1'b0, 4'b0100});
    tbl.push_back('{4'b1111, 1'b0, 4'b1000});
    tbl.push_back('{4'b1111, 1'b0, 4'b0001});
    tbl.push_back('{4'b1111, 1'b0, 4'b0010});
    // fairness between 0 and 3
    tbl.push_back('{4'b1001, 1'b0, 4'b1000});
    tbl.push_back('{4'b1001, 1'b0, 4'b0001});
    tbl.push_back('{4'b1001, 1'b0, 4'b1000});
    tbl.push_back('{4'b1001, 1'b0, 4'b0001});
    // pause, gaps and wrap-around
    tbl.push_back('{4'b1111, 1'b1, 4'b0000});
    tbl.push_back('{4'b0110, 1'b0, 4'b0010});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0100, 1'b0, 4'b0100});
    tbl.push_back('{4'b0011, 1'b0, 4'b0001});
    tbl.push_back('{4'b0011, 1'b0, 4'b0010});
    tbl.push_back('{4'b0101, 1'b1, 4'b0000});
    tbl.push_back('{4'b0101, 1'b0, 4'b0100});
    tbl.push_back('{4'b0101, 1'b0, 4'b0001});
    for (int k = 0; k < 4; k++) tbl.push_back('{4'b0000, 1'b0, 4'b0000});

    // single add from requester 2
    do_reset();
    step();
    set_ops(2, {32'h3F800000, 32'h40000000}, {32'h40000000, 32'h3F800000}, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'h4);
    push_exp(2);
    step();
    bus.req_valid = '0;
    #1;
    check("single_add_start", 64'(add_start), 64'h1);
    check("single_add_a", add_a, 64'h3F800000_40000000);
    check("single_add_b", add_b, 64'h40000000_3F800000);
    check("single_add_op", 64'(add_op), 64'h0);
    check("single_busy", 64'(busy), 64'h1);
    step();
    #1;
    check("single_no_early_resp", 64'(bus.resp_valid), 64'h0);
    step();
    #1;
    check("single_resp_valid", 64'(bus.resp_valid), 64'h1);
    check("single_resp_id", 64'(bus.resp_id), 64'h2);
    check("single_resp_data", bus.resp_data, 64'h40400000_40400000);
    step();
    #1;
    check("single_idle_busy", 64'(busy), 64'h0);
    load_defaults();

    // grant table
    do_reset();
    foreach (tbl[r]) begin
      step();
      bus.req_valid = tbl[r].valid;
      pause = tbl[r].pause;
      #1;
      check($sformatf("tbl_ready_%0d", r), 64'(bus.req_ready), 64'(tbl[r].exp_ready));
      if (tbl[r].exp_ready != '0) push_exp(oh2id(tbl[r].exp_ready));
    end

    // pause after a grant (ptr=1 here)
    step();
    bus.req_valid = 4'b0010;
    #1;
    check("pause_first_ready", 64'(bus.req_ready), 64'h2);
    push_exp(1);
    for (int k = 1; k <= 5; k++) begin
      step();
      bus.req_valid = 4'b1111;
      pause = 1'b1;
      #1;
      check("pause_ready", 64'(bus.req_ready), 64'h0);
      if (k == 1) check("pause_add_start", 64'(add_start), 64'h1);
      if (k == 3) begin
        check("pause_resp_valid", 64'(bus.resp_valid), 64'h1);
        check("pause_resp_id", 64'(bus.resp_id), 64'h1);
      end
      if (k == 4) check("pause_busy_low", 64'(busy), 64'h0);
    end
    step();
    pause = 1'b0;
    #1;
    check("unpause_ready", 64'(bus.req_ready), 64'h4);
    push_exp(2);
    idle(5);

    // reset mid-flight (ptr=3 here)
    step();
    bus.req_valid = 4'b1111;
    #1;
    check("mid_ready_a", 64'(bus.req_ready), 64'h8);
    push_exp(3);
    step();
    #1;
    check("mid_ready_b", 64'(bus.req_ready), 64'h1);
    push_exp(0);
    step();
    rst = 1'b1;
    #1;
    check("mid_ready_rst", 64'(bus.req_ready), 64'h0);
    check("mid_add_ce_rst", 64'(add_ce), 64'h0);
    flush_inflight();
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    check("mid_add_start", 64'(add_start), 64'h0);
    check("mid_busy", 64'(busy), 64'h0);
    check("mid_resp_valid_a", 64'(bus.resp_valid), 64'h0);
    check("mid_ptr", 64'(dbg_ptr), 64'h0);
    check("mid_add_a", add_a, 64'h0);
    check("mid_ready_after", 64'(bus.req_ready), 64'h2);
    push_exp(1);
    step();
    bus.req_valid = '0;
    #1;
    check("mid_resp_valid_b", 64'(bus.resp_valid), 64'h0);
    idle(4);

    // subtract passthrough (ptr=2 here)
    step();
    set_ops(2, {i2f(3), i2f(3)}, {i2f(3), i2f(3)}, 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    check("sub_ready", 64'(bus.req_ready), 64'h4);
    push_exp(2);
    step();
    bus.req_valid = '0;
    #1;
    check("sub_add_start", 64'(add_start), 64'h1);
    check("sub_add_op", 64'(add_op), 64'h1);
    step();
    step();
    #1;
    check("sub_resp_valid", 64'(bus.resp_valid), 64'h1);
    check("sub_resp_data", bus.resp_data, 64'h0);
    load_defaults();
    idle(4);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/complex_addsub_rr_scheduler.md
Name: complex_addsub_rr_scheduler

Overview:
- Shares one pipelined complex adder/subtractor (64-bit operands: real in [63:32], imaginary in [31:0], IEEE-754 single each) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- Drives the adder's start/operand/op inputs and tracks each in-flight operation with a tag pipeline.
- Returns every result with the originating requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= NUM_REQ.
- ADD_LATENCY, 2, cycles from add_start high to the adder result being valid (matches the adder's start→finish_dash delay).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- pause  in  1  when high, no new grants; in-flight operations still complete
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero)
- req_a  in  NUM_REQ*64  operand A, requester i at [64*i+63:64*i]
- req_b  in  NUM_REQ*64  operand B, same packing
- req_op  in  NUM_REQ  add/subtract select, passed unchanged to adder
- add_start  out  1  issue strobe to adder (registered)
- add_a  out  64  registered operand A to adder
- add_b  out  64  registered operand B to adder
- add_op  out  1  registered op to adder
- add_ce  out  1  tied high while not in reset
- add_result  in  64  adder result
- resp_valid  out  1  result valid strobe (1 cycle)
- resp_id  out  ID_W  requester ID of resp_data
- resp_data  out  64  result, equal to add_result in the resp_valid cycle
- busy  out  1  high while any operation is in flight or being issued

Behaviour:
- Handshake: transfer on requester i in cycle t when req_valid[i] && req_ready[i]. Requester holds a/b/op stable while valid and not ready. No response backpressure: resp_valid is a 1-cycle strobe that must be consumed.
- Arbitration: round-robin with priority pointer ptr. Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1; first valid requester wins.
- req_ready is all-zero when pause=1, when rst=1, or when no valid requester.
- After a grant to i, ptr <= (i+1) mod NUM_REQ; ptr is unchanged on cycles without a grant.
- Issue: grant in cycle t gives add_start=1 in cycle t+1, with add_a/add_b/add_op holding the winner's values sampled at t. add_start=0 otherwise; add_a/add_b/add_op hold their last values when idle.
- Tag pipeline: shift register of depth ADD_LATENCY carrying {valid, id}, loaded from the issue stage.
- Response: resp_valid=1 in cycle t+1+ADD_LATENCY, with resp_id=i and resp_data=add_result in that cycle.
- Back-to-back grants every cycle yield back-to-back responses in grant order; no reordering, no bubbles inserted.
- busy = add_start OR any tag valid.
- pause asserted mid-stream blocks only new grants. Responses for already-granted operations still arrive on schedule.
- Reset values (cycle after rst sampled high): ptr=0, add_start=0, add_a=0, add_b=0, add_op=0, all tag valids=0, resp_valid=0, resp_id=0, resp_data=0, busy=0; add_ce=0 during rst.
- Reset mid-operation: in-flight tags are discarded and no resp_valid is produced for them, even if the adder later outputs data.
- A request with req_valid dropped before being granted is simply skipped; no state is retained for it.
- Simultaneous grant and response in the same cycle are independent and both proceed.

Test Plan:
- Single op: after reset, req_valid[2]=1, A={0x3F800000,0x40000000} (1+2j), B={0x40000000,0x3F800000} (2+1j), op=add. Expect req_ready[2]=1 at t; add_start=1 at t+1; resp_valid=1 at t+3 with resp_id=2 and resp_data={0x40400000,0x40400000} (3+3j).
- All four requesters valid continuously from ptr=0: grants in order 0,1,2,3,0,… every cycle. Responses arrive every cycle, IDs in that same order, starting 3 cycles after the first grant.
- Fairness: requesters 0 and 3 valid, last grant was to 3 (ptr=0). Grants alternate 0,3,0,3; requester 0 is never granted twice in a row while 3 is waiting.
- Pause: grant issued at t, pause=1 from t+1 to t+5. No req_ready during the pause; the response for the t grant still appears at t+3; busy=0 at t+4.
- Reset mid-flight: two grants at t and t+1, rst=1 at t+2. No resp_valid at t+3 or t+4; all outputs at reset values; after rst drops, the first grant goes to the lowest-index valid requester (ptr=0).
- Subtract passthrough: op=sub with A=B=(3+3j). add_op=1 in the issue cycle and resp_data=0x0000000000000000.
